hpdl_term_ctrl: RTL and testbench

//  Multi-module HPDL-1414 terminal controller: accepts a byte stream (UART receiver output), keeps a

---
 rtl/hpdl_term_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hpdl_term_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdl_term_ctrl.sv
// HPDL-1414 terminal controller: a command FSM turns a byte stream into a character buffer,
// and a free-running refresh engine scans that buffer onto NUM_MODULES displays with a caret.
module hpdl_term_ctrl #(
   parameter int         NUM_MODULES = 4,
   parameter int         CLK_DIV     = 1024,
   parameter int         BLINK_DIV   = 4194304,
   parameter bit         SCROLL_EN   = 1'b1,
   parameter bit         CARET_EN    = 1'b1,
   parameter logic [6:0] CARET_CHAR  = 7'h5F,
   localparam int        DEPTH       = 4 * NUM_MODULES,
   localparam int        CW          = $clog2(DEPTH + 1)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [7:0]             IN_DATA,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   output logic [6:0]             HPDL_D,
   output logic [1:0]             HPDL_A,
   output logic [NUM_MODULES-1:0] HPDL_WR_N,
   output logic [CW-1:0]          CURSOR
);
   localparam int AW = $clog2(DEPTH);
   localparam int MW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
   localparam int SW = $clog2(2 * CLK_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   localparam logic [6:0]    SPACE    = 7'h20;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [CW-1:0] END_POS  = CW'(DEPTH);
   localparam logic [SW-1:0] SLOT_END = SW'(2 * CLK_DIV - 1);
   localparam logic [SW-1:0] HALF_POS = SW'(CLK_DIV);
   localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_SCROLL
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cursor_q, cursor_d;
   logic [6:0]      pend_q, pend_d;

   logic [6:0]      mem [DEPTH];
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [6:0]      mem_wdata;

   logic [7:0]      mapped;
   logic            printable;

   logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
   logic [AW-1:0]   place_q, place_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_q, blink_d;
   logic [6:0]      d_q, d_d;
   logic [1:0]      a_q, a_d;
   logic [NUM_MODULES-1:0] wr_n_q, wr_n_d;
   logic            slot_end;
   logic            blink_end;
   logic [MW-1:0]   mod_idx;

   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      mapped    = (IN_DATA >= 8'h61 && IN_DATA <= 8'h7A) ? IN_DATA - 8'h20 : IN_DATA;
      printable = (mapped >= 8'h20) && (mapped <= 8'h5F);
      state_d   = state_q;
      idx_d     = idx_q;
      cursor_d  = cursor_q;
      pend_d    = pend_q;
      mem_we    = 1'b0;
      mem_waddr = idx_q;
      mem_wdata = SPACE;

      case (state_q)
         S_IDLE: begin
            if (IN_VALID) begin
               if (printable) begin
                  if (cursor_q < END_POS) begin
                     mem_we    = 1'b1;
                     mem_waddr = cursor_q[AW-1:0];
                     mem_wdata = mapped[6:0];
                     cursor_d  = cursor_q + CW'(1);
                  end else if (SCROLL_EN) begin
                     pend_d  = mapped[6:0];
                     idx_d   = '0;
                     state_d = S_SCROLL;
                  end
               end else begin
                  case (mapped)
                     8'h08: begin
                        if (cursor_q != '0) begin
                           cursor_d  = cursor_q - CW'(1);
                           mem_we    = 1'b1;
                           mem_waddr = cursor_d[AW-1:0];
                        end
                     end
                     8'h0D: cursor_d = '0;
                     8'h0C: begin
                        idx_d   = '0;
                        state_d = S_CLEAR;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_CLEAR: begin
            mem_we   = 1'b1;
            cursor_d = '0;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         S_SCROLL: begin
            // Each step reads the right neighbour before it is itself overwritten next cycle.
            mem_we = 1'b1;
            if (idx_q == LAST_IDX) begin
               mem_wdata = pend_q;
               idx_d     = '0;
               state_d   = S_IDLE;
            end else begin
               mem_wdata = mem[idx_q + AW'(1)];
               idx_d     = idx_q + AW'(1);
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_CLEAR;
         idx_q    <= '0;
         cursor_q <= '0;
         pend_q   <= SPACE;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cursor_q <= cursor_d;
         pend_q   <= pend_d;
      end
   end

   // NOTE: the character store has no reset; the CLEAR pass after reset initialises it.
   always_ff @(posedge CLK) begin
      if (mem_we && !RST) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      slot_end    = (slot_cnt_q == SLOT_END);
      slot_cnt_d  = slot_end ? '0 : slot_cnt_q + SW'(1);
      place_d     = place_q;
      if (slot_end) begin
         place_d = (place_q == LAST_IDX) ? '0 : place_q + AW'(1);
      end
      blink_end   = (blink_cnt_q == BLINK_END);
      blink_cnt_d = blink_end ? '0 : blink_cnt_q + BW'(1);
      blink_d     = blink_q ^ blink_end;
      mod_idx     = MW'(place_d >> 2);

      // Bus values are latched once per slot so they stay stable around the strobe.
      d_d = d_q;
      a_d = a_q;
      if (slot_end) begin
         a_d = 2'd3 - place_d[1:0];
         if (CARET_EN && blink_q && (cursor_q == CW'(place_d))) begin
            d_d = CARET_CHAR;
         end else begin
            d_d = mem[place_d];
         end
      end

      wr_n_d = '1;
      if (slot_cnt_d >= HALF_POS) begin
         wr_n_d[mod_idx] = 1'b0;
      end
   end

   // Reset bus value 0x20 doubles as the first slot's (still blank) place-0 contents.
   always_ff @(posedge CLK) begin
      if (RST) begin
         slot_cnt_q  <= '0;
         place_q     <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         d_q         <= SPACE;
         a_q         <= 2'b11;
         wr_n_q      <= '1;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         place_q     <= place_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         d_q         <= d_d;
         a_q         <= a_d;
         wr_n_q      <= wr_n_d;
      end
   end

   assign IN_READY  = (state_q == S_IDLE);
   assign HPDL_D    = d_q;
   assign HPDL_A    = a_q;
   assign HPDL_WR_N = wr_n_q;
   assign CURSOR    = cursor_q;

endmodule

// File: tb/tb_hpdl_term_ctrl.sv
// Bench for hpdl_term_ctrl: stimulus pushes expected display frames, a monitor on the write
// strobes compares each refreshed place; a second instance covers the no-scroll variant.
module tb_hpdl_term_ctrl;
   localparam int NM      = 2;
   localparam int DEPTH   = 8;
   localparam int CLK_DIV = 4;

   typedef logic [DEPTH-1:0][6:0] frame_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [6:0]    hpdl_d;
   logic [1:0]    hpdl_a;
   logic [NM-1:0] hpdl_wr_n;
   logic [3:0]    cursor;

   logic [7:0]    ns_data = '0;
   logic          ns_valid = 1'b0;
   logic          ns_ready;
   logic [6:0]    ns_d;
   logic [1:0]    ns_a;
   logic [NM-1:0] ns_wr_n;
   logic [3:0]    ns_cursor;

   int            checks = 0;
   int            failures = 0;
   frame_t        exp_q[$];
   logic [7:0]    seen = '0;

   always #5 clk = ~clk;

   hpdl_term_ctrl #(
      .NUM_MODULES(NM), .CLK_DIV(CLK_DIV), .BLINK_DIV(16),
      .SCROLL_EN(1'b1), .CARET_EN(1'b1), .CARET_CHAR(7'h5F)
   ) dut (
      .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
      .HPDL_D(hpdl_d), .HPDL_A(hpdl_a), .HPDL_WR_N(hpdl_wr_n), .CURSOR(cursor)
   );

   hpdl_term_ctrl #(
      .NUM_MODULES(NM), .CLK_DIV(CLK_DIV), .BLINK_DIV(16),
      .SCROLL_EN(1'b0), .CARET_EN(1'b1), .CARET_CHAR(7'h5F)
   ) dut_ns (
      .CLK(clk), .RST(rst), .IN_DATA(ns_data), .IN_VALID(ns_valid), .IN_READY(ns_ready),
      .HPDL_D(ns_d), .HPDL_A(ns_a), .HPDL_WR_N(ns_wr_n), .CURSOR(ns_cursor)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic frame_t mk(input string s);
      frame_t f;
      byte    c;
      for (int i = 0; i < DEPTH; i++) begin
         c    = s[i];
         f[i] = c[6:0];
      end
      return f;
   endfunction

   // Monitor: on the first sample of each write strobe, compare that place against the
   // frame at the head of the queue; the frame is retired once all places were seen.
   initial begin
      logic prev_strobe;
      logic strobe;
      int   m;
      int   p;
      prev_strobe = 1'b0;
      forever begin
         @(negedge clk);
         strobe = (hpdl_wr_n != '1);
         if (rst) begin
            prev_strobe = 1'b0;
         end else begin
            if (strobe && !prev_strobe && exp_q.size() > 0) begin
               check("wr_n_onehot", $countones(~hpdl_wr_n), 1);
               m = (hpdl_wr_n == 2'b01) ? 1 : 0;
               p = 4 * m + 3 - int'(hpdl_a);
               if (!seen[p]) begin
                  check($sformatf("place%0d_d", p), hpdl_d, exp_q[0][p]);
                  seen[p] = 1'b1;
               end
               if (seen == 8'hFF) begin
                  void'(exp_q.pop_front());
                  seen = '0;
               end
            end
            prev_strobe = strobe;
         end
      end
   end

   task automatic send(input logic [7:0] b, input bit to_ns = 1'b0);
      int n = 0;
      @(negedge clk);
      if (to_ns) begin ns_data = b; ns_valid = 1'b1; end
      else       begin in_data = b; in_valid = 1'b1; end
      while (!(to_ns ? ns_ready : in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(to_ns ? ns_ready : in_ready)) check("send_timeout", to_ns ? ns_ready : in_ready, 1);
      else @(posedge clk);
      #1;
      in_valid = 1'b0;
      ns_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input bit to_ns = 1'b0);
      for (int i = 0; i < s.len(); i++) send(s[i], to_ns);
   endtask

   // Counts busy samples starting with the current one.
   task automatic wait_busy(input string name, input int exp);
      int n = 0;
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(name, n, exp);
   endtask

   // Waits one full slot so every later strobe belongs to a slot loaded after the last write.
   task automatic expect_frame(input string s);
      int n = 0;
      repeat (2 * CLK_DIV + 1) @(negedge clk);
      exp_q.push_back(mk(s));
      while (exp_q.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         check("frame_timeout", exp_q.size(), 0);
         exp_q.delete();
         seen = '0;
      end
   endtask

   task automatic capture_ns(input string s);
      frame_t     f = mk(s);
      logic [7:0] got = '0;
      logic       prev = 1'b0;
      int         m;
      int         p;
      repeat (2 * CLK_DIV + 1) @(negedge clk);
      for (int n = 0; n < 100 && got != 8'hFF; n++) begin
         @(negedge clk);
         if (ns_wr_n != '1 && !prev) begin
            m = (ns_wr_n == 2'b01) ? 1 : 0;
            p = 4 * m + 3 - int'(ns_a);
            if (!got[p]) begin
               check($sformatf("ns_place%0d_d", p), ns_d, f[p]);
               got[p] = 1'b1;
            end
         end
         prev = (ns_wr_n != '1);
      end
      check("ns_frame_complete", got, 8'hFF);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_wn;
      int         p;

      // Reset and first refresh frame: CLEAR for 8 cycles, slot timing, digit order.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cursor", cursor, 0);
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         p      = k / 8;
         exp_wn = 2'b11;
         if (k % 8 >= 4) exp_wn[p / 4] = 1'b0;
         check($sformatf("t1_k%0d", k), {in_ready, hpdl_wr_n, hpdl_a, hpdl_d},
               {k >= 8, exp_wn, 2'(3 - p % 4), 7'h20});
         if (k == 0) rst = 1'b0;
      end

      // Lowercase mapping; caret phase is on when place 3 is refreshed.
      send_str("ab1");
      @(negedge clk);
      check("t2_cursor", cursor, 3);
      expect_frame("AB1_    ");

      // Fill to the end, then scroll.
      send(8'h0D);
      send_str("ABCDEFGH");
      @(negedge clk);
      check("t3_cursor_full", cursor, 8);
      expect_frame("ABCDEFGH");
      send("I");
      @(negedge clk);
      wait_busy("t3_scroll_busy", 8);
      check("t3_cursor_scroll", cursor, 8);
      expect_frame("BCDEFGHI");

      // Same stream with scrolling disabled: last byte is dropped.
      send_str("ABCDEFGHI", 1'b1);
      @(negedge clk);
      check("t3ns_ready", ns_ready, 1);
      check("t3ns_cursor", ns_cursor, 8);
      capture_ns("ABCDEFGH");

      // Backspace past column 0, carriage return, ignored codes.
      send(8'h0C);
      @(negedge clk);
      wait_busy("t4_ff_busy", 8);
      check("t4_cursor_clr", cursor, 0);
      send_str("AB");
      send(8'h08);
      @(negedge clk);
      check("t4_bksp1", cursor, 1);
      send(8'h08);
      send(8'h08);
      @(negedge clk);
      check("t4_bksp3", cursor, 0);
      expect_frame("_       ");
      send_str("XY");
      send(8'h0D);
      send(8'h7A);
      send(8'h60);
      send(8'h7B);
      send(8'h01);
      @(negedge clk);
      check("t4_cursor_cr", cursor, 1);
      expect_frame("ZY      ");

      // Caret on at place 4, off at place 5, then form feed.
      send(8'h0C);
      @(negedge clk);
      wait_busy("t5_pre_clear", 8);
      send_str("HELL");
      expect_frame("HELL_   ");
      send("O");
      @(negedge clk);
      check("t5_cursor", cursor, 5);
      expect_frame("HELLO   ");
      send(8'h0C);
      @(negedge clk);
      wait_busy("t5_clear_busy", 8);
      check("t5_cursor_clr", cursor, 0);
      expect_frame("_       ");

      // Reset in the middle of a scroll.
      send_str("ABCDEFGH");
      send("I");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_reset_outs", {in_ready, hpdl_wr_n, hpdl_a, hpdl_d, cursor},
            {1'b0, 2'b11, 2'b11, 7'h20, 4'd0});
      rst = 1'b0;
      wait_busy("t6_clear_busy", 8);
      check("t6_cursor", cursor, 0);
      expect_frame("_       ");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
